// File: rtl/redun_to_canonical_pkg.sv
// redun_pkg: shared FSM state type and width helper for the redundant-to-canonical converter
package redun_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} redun_state_t;
  function automatic int carry_len(input int dsp_bit_len, input int word_len);
    return dsp_bit_len - word_len + 1;
  endfunction
endpackage

// File: rtl/redun_to_canonical_if.sv
// redun_to_canonical_if: redundant vector in, canonical chunk stream out
interface redun_to_canonical_if
  import redun_pkg::*;
#(
  parameter int NUM_ELEMENTS    = 66,
  parameter int DSP_BIT_LEN     = 17,
  parameter int WORD_LEN        = 16,
  parameter int LIMBS_PER_CYCLE = 6,
  parameter int CARRY_LEN       = carry_len(DSP_BIT_LEN, WORD_LEN)
) ();
  logic                                          i_val;
  logic [NUM_ELEMENTS-1:0][DSP_BIT_LEN-1:0]      i_dat;
  logic                                          o_rdy;
  logic                                          o_val;
  logic [LIMBS_PER_CYCLE-1:0][WORD_LEN-1:0]      o_dat;
  logic                                          o_last;
  logic [CARRY_LEN-1:0]                          o_carry;
  logic                                          i_rdy;
  modport master (output i_val, i_dat, i_rdy, input o_rdy, o_val, o_dat, o_last, o_carry);
  modport slave  (input i_val, i_dat, i_rdy, output o_rdy, o_val, o_dat, o_last, o_carry);
endinterface

// File: rtl/redun_to_canonical_carry_chunk.sv
// redun_carry_chunk: ripples a carry through one chunk of redundant limbs
module redun_carry_chunk
  import redun_pkg::*;
#(
  parameter int LIMBS       = 6,
  parameter int DSP_BIT_LEN = 17,
  parameter int WORD_LEN    = 16,
  parameter int CARRY_LEN   = carry_len(DSP_BIT_LEN, WORD_LEN)
) (
  input  logic [LIMBS-1:0][DSP_BIT_LEN-1:0] limbs,
  input  logic [CARRY_LEN-1:0]              carry_in,
  output logic [LIMBS-1:0][WORD_LEN-1:0]    words,
  output logic [CARRY_LEN-1:0]              carry_out
);
  logic [LIMBS:0][CARRY_LEN-1:0] c;
  assign c[0] = carry_in;
  for (genvar i = 0; i < LIMBS; i++) begin : g_limb
    logic [DSP_BIT_LEN:0] s;
    assign s = {1'b0, limbs[i]} + (DSP_BIT_LEN+1)'(c[i]);
    assign words[i] = s[WORD_LEN-1:0];
    assign c[i+1] = s[DSP_BIT_LEN:WORD_LEN];
  end
  assign carry_out = c[LIMBS];
endmodule

// File: rtl/redun_to_canonical.sv
// redun_to_canonical: resolves a redundant vector into canonical words, one chunk per beat
module redun_to_canonical
  import redun_pkg::*;
#(
  parameter int NUM_ELEMENTS    = 66,
  parameter int DSP_BIT_LEN     = 17,
  parameter int WORD_LEN        = 16,
  parameter int LIMBS_PER_CYCLE = 6
) (
  input logic                i_clk,
  input logic                i_rst,
  redun_to_canonical_if.slave bus
);
  localparam int NUM_CHUNKS = NUM_ELEMENTS / LIMBS_PER_CYCLE;
  localparam int CARRY_LEN  = carry_len(DSP_BIT_LEN, WORD_LEN);
  localparam int IDX_W      = $clog2(NUM_CHUNKS + 1);
  if (NUM_ELEMENTS % LIMBS_PER_CYCLE != 0) begin : g_bad_cfg
    $fatal(1, "NUM_ELEMENTS must be a multiple of LIMBS_PER_CYCLE");
  end
  redun_state_t                                   state, nxt;
  logic [NUM_ELEMENTS-1:0][DSP_BIT_LEN-1:0]       vec_q;
  logic [IDX_W-1:0]                               idx_q;
  logic [CARRY_LEN-1:0]                           carry_q, cout;
  logic [LIMBS_PER_CYCLE-1:0][WORD_LEN-1:0]       words;
  logic                                           accept, load, last;
  redun_carry_chunk #(
    .LIMBS(LIMBS_PER_CYCLE), .DSP_BIT_LEN(DSP_BIT_LEN), .WORD_LEN(WORD_LEN)
  ) u_chunk (
    .limbs(vec_q[idx_q*LIMBS_PER_CYCLE +: LIMBS_PER_CYCLE]),
    .carry_in(carry_q),
    .words(words),
    .carry_out(cout)
  );
  // state register
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) state <= IDLE;
    else state <= nxt;
  // next state: a chunk load advances LOAD/RUN, the final handshake returns to IDLE
  always_comb
    nxt = state == IDLE  ? (bus.i_val ? LOAD : IDLE) :
          state == DRAIN ? (bus.o_val && bus.i_rdy ? IDLE : DRAIN) :
          load           ? (last ? DRAIN : RUN) : state;
  // FSM decode: ready only when idle, output register loads when empty or being drained
  always_comb begin
    bus.o_rdy = state == IDLE;
    accept    = bus.o_rdy && bus.i_val;
    load      = (state == LOAD || state == RUN) && (!bus.o_val || bus.i_rdy);
    last      = idx_q == IDX_W'(NUM_CHUNKS - 1);
  end
  // vector buffer needs no reset; it is always written before use
  always_ff @(posedge i_clk)
    if (accept) vec_q <= bus.i_dat;
  // carry, chunk index and output registers; nothing moves while stalled
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      carry_q     <= '0;
      idx_q       <= '0;
      bus.o_val   <= 1'b0;
      bus.o_last  <= 1'b0;
      bus.o_carry <= '0;
      bus.o_dat   <= '0;
    end else if (accept) begin
      carry_q <= '0;
      idx_q   <= '0;
    end else if (load) begin
      carry_q     <= cout;
      idx_q       <= idx_q + 1'b1;
      bus.o_val   <= 1'b1;
      bus.o_last  <= last;
      bus.o_carry <= last ? cout : '0;
      bus.o_dat   <= words;
    end else if (state == DRAIN && bus.o_val && bus.i_rdy) begin
      bus.o_val  <= 1'b0;
      bus.o_last <= 1'b0;
    end
endmodule

// File: tb/tb_redun_to_canonical.sv
// tb_redun_to_canonical: directed vectors against hand-computed chunks
module tb_redun_to_canonical;
  localparam int NE = 8, L = 4, D = 17, W = 16, CL = D - W + 1;
  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  int total = 0;
  int bad = 0;
  always #5 i_clk = ~i_clk;
  redun_to_canonical_if #(.NUM_ELEMENTS(NE), .DSP_BIT_LEN(D), .WORD_LEN(W), .LIMBS_PER_CYCLE(L)) bus ();
  redun_to_canonical #(.NUM_ELEMENTS(NE), .DSP_BIT_LEN(D), .WORD_LEN(W), .LIMBS_PER_CYCLE(L)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .bus(bus)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [NE-1:0][D-1:0] fill(input logic [D-1:0] v);
    logic [NE-1:0][D-1:0] r;
    for (int i = 0; i < NE; i++) r[i] = v;
    return r;
  endfunction
  task automatic run_vec(input string tag, input logic [NE-1:0][D-1:0] v, input logic [63:0] c0,
                         input logic [63:0] c1, input logic [CL-1:0] cry, input int stall, input bit busy);
    @(negedge i_clk);
    check({tag, " rdy_idle"}, bus.o_rdy, 1);
    bus.i_val = 1'b1;
    bus.i_dat = v;
    bus.i_rdy = 1'b1;
    @(negedge i_clk);
    check({tag, " val_t1"}, bus.o_val, 0);
    check({tag, " rdy_busy"}, bus.o_rdy, 0);
    if (busy) bus.i_dat = ~v;
    else bus.i_val = 1'b0;
    @(negedge i_clk);
    bus.i_val = 1'b0;
    check({tag, " val_c0"}, bus.o_val, 1);
    check({tag, " dat_c0"}, bus.o_dat, c0);
    check({tag, " last_c0"}, bus.o_last, 0);
    if (stall > 0) begin
      bus.i_rdy = 1'b0;
      for (int k = 0; k < stall; k++) begin
        @(negedge i_clk);
        check({tag, " stall_val"}, bus.o_val, 1);
        check({tag, " stall_dat"}, bus.o_dat, c0);
        check({tag, " stall_rdy"}, bus.o_rdy, 0);
      end
      bus.i_rdy = 1'b1;
    end
    @(negedge i_clk);
    check({tag, " val_c1"}, bus.o_val, 1);
    check({tag, " dat_c1"}, bus.o_dat, c1);
    check({tag, " last_c1"}, bus.o_last, 1);
    check({tag, " carry"}, bus.o_carry, cry);
    @(negedge i_clk);
    check({tag, " val_end"}, bus.o_val, 0);
    check({tag, " last_end"}, bus.o_last, 0);
    check({tag, " rdy_end"}, bus.o_rdy, 1);
  endtask
  logic [NE-1:0][D-1:0] v3;
  initial begin
    bus.i_val = 1'b0;
    bus.i_rdy = 1'b1;
    bus.i_dat = '0;
    v3 = '0;
    v3[3] = 17'h10000;
    @(negedge i_clk);
    check("rst_rdy", bus.o_rdy, 1);
    check("rst_val", bus.o_val, 0);
    check("rst_last", bus.o_last, 0);
    check("rst_carry", bus.o_carry, 0);
    check("rst_dat", bus.o_dat, 0);
    @(negedge i_clk);
    i_rst = 1'b0;
    run_vec("nocarry", fill(17'h0FFFF), 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'd0, 0, 1'b0);
    run_vec("maxcarry", fill(17'h1FFFF), 64'h0001_0001_0000_FFFF, 64'h0001_0001_0001_0001, 2'd2, 0, 1'b0);
    run_vec("cross", v3, 64'h0, 64'h0000_0000_0000_0001, 2'd0, 0, 1'b0);
    run_vec("bkpr", fill(17'h1FFFF), 64'h0001_0001_0000_FFFF, 64'h0001_0001_0001_0001, 2'd2, 3, 1'b0);
    run_vec("busy", fill(17'h0FFFF), 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'd0, 0, 1'b1);
    @(negedge i_clk);
    bus.i_val = 1'b1;
    bus.i_dat = fill(17'h1FFFF);
    @(negedge i_clk);
    bus.i_val = 1'b0;
    @(negedge i_clk);
    check("midrst dat_c0", bus.o_dat, 64'h0001_0001_0000_FFFF);
    @(negedge i_clk);
    check("midrst val_c1", bus.o_val, 1);
    i_rst = 1'b1;
    #1;
    check("midrst val_async", bus.o_val, 0);
    check("midrst last_async", bus.o_last, 0);
    @(negedge i_clk);
    i_rst = 1'b0;
    check("midrst rdy", bus.o_rdy, 1);
    run_vec("after_rst", v3, 64'h0, 64'h0000_0000_0000_0001, 2'd0, 0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
